// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of a single-port word data memory.
// Port 0 is the CPU memory stage and port 1 is a secondary master.
// Partial (byte-enabled) stores become a read-modify-write, so the
// memory only ever sees whole-word writes.
module dm_port_arbiter #(
  parameter int AW         = 12,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [3:0]    be0,
  input  logic [3:0]    be1,
  input  logic [31:0]   addr0,
  input  logic [31:0]   addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [31:0]   rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic {IDLE, RMW} state_t;

  state_t        state;
  state_t        state_next;
  logic          last_grant;
  logic          rmw_port;
  logic [AW-1:0] rmw_addr;
  logic [31:0]   merge;

  logic          sel1;
  logic          win_req;
  logic          win_we;
  logic [3:0]    win_be;
  logic [31:0]   win_addr;
  logic [31:0]   win_wdata;
  logic [AW-1:0] win_word;
  logic [31:0]   win_mask;
  logic [31:0]   merge_next;
  logic          load_grant;
  logic          start_rmw;
  logic          unused_addr_bits;

  // Pick the winning port and mux its request fields; port 1 wins only
  // when it is alone or when round-robin says port 0 went last.
  always_comb begin
    sel1       = req1 && (!req0 || ((FIXED_PRIO == 0) && !last_grant));
    win_req    = req0 || req1;
    win_we     = sel1 ? we1    : we0;
    win_be     = sel1 ? be1    : be0;
    win_addr   = sel1 ? addr1  : addr0;
    win_wdata  = sel1 ? wdata1 : wdata0;
    win_word   = win_addr[AW+1:2];
    win_mask   = {{8{win_be[3]}}, {8{win_be[2]}}, {8{win_be[1]}}, {8{win_be[0]}}};
    merge_next = (mem_rdata & ~win_mask) | (win_wdata & win_mask);
  end

  // Byte-offset and out-of-range address bits are deliberately ignored.
  assign unused_addr_bits = ^{win_addr[31:AW+2], win_addr[1:0]};

  // Next-state and memory/grant outputs; everything is forced quiet while
  // reset is asserted so an in-flight RMW write is dropped.
  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    busy       = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    load_grant = 1'b0;
    start_rmw  = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (win_req) begin
            mem_addr = win_word;
            if (!win_we) begin
              load_grant = 1'b1;
              gnt0       = !sel1;
              gnt1       = sel1;
            end else if (win_be == 4'b1111) begin
              mem_we    = 1'b1;
              mem_wdata = win_wdata;
              gnt0      = !sel1;
              gnt1      = sel1;
            end else if (win_be == 4'b0000) begin
              gnt0 = !sel1;
              gnt1 = sel1;
            end else begin
              start_rmw  = 1'b1;
              state_next = RMW;
            end
          end
        end
        RMW: begin
          busy       = 1'b1;
          mem_addr   = rmw_addr;
          mem_we     = 1'b1;
          mem_wdata  = merge;
          gnt0       = !rmw_port;
          gnt1       = rmw_port;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Remember which port was granted last for round-robin fairness.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      last_grant <= 1'b1;
    else if (gnt0) last_grant <= 1'b0;
    else if (gnt1) last_grant <= 1'b1;
  end

  // Capture load data and raise the granted port's rvalid one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid0 <= load_grant && !sel1;
      rvalid1 <= load_grant && sel1;
      if (load_grant) rdata <= mem_rdata;
    end
  end

  // Latch the merged word, owner and address for the RMW write cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      merge    <= '0;
      rmw_port <= 1'b0;
      rmw_addr <= '0;
    end else if (start_rmw) begin
      merge    <= merge_next;
      rmw_port <= sel1;
      rmw_addr <= win_word;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: directed scenarios followed by
// randomized traffic from both ports against a word-level memory model.
module tb_dm_port_arbiter;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [3:0]  be0, be1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, mem_we;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;

  logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_busy, fp_mem_we;
  logic [31:0] fp_rdata, fp_mem_wdata;
  logic [11:0] fp_mem_addr;
  logic [31:0] fp_mem_rdata = 32'h0;

  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  logic [31:0] mem     [0:4095] = '{default: 32'h0};
  logic [31:0] ref_mem [0:4095] = '{default: 32'h0};

  exp_t q0[$];
  exp_t q1[$];
  bit          pend [2];
  logic [31:0] pend_data [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.AW(12), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dm_port_arbiter #(.AW(12), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(fp_gnt0), .gnt1(fp_gnt1), .rvalid0(fp_rvalid0), .rvalid1(fp_rvalid1),
    .rdata(fp_rdata), .busy(fp_busy), .mem_addr(fp_mem_addr), .mem_we(fp_mem_we),
    .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata)
  );

  // Memory environment: combinational read, synchronous word write.
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    pre_we   = 1'b1;
    pre_addr = 12'(idx);
    pre_data = data;
    ref_mem[idx] = data;
    step();
    pre_we = 1'b0;
  endtask

  // Drive a request on port p and record the response it must produce.
  task automatic applyStimulus(input int p, input bit we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          idx;
    logic [31:0] mask;
    idx  = int'(addr[13:2]);
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (be[b]) mask[8*b +: 8] = 8'hFF;
    e.is_load = !we;
    e.data    = ref_mem[idx];
    if (we) ref_mem[idx] = (ref_mem[idx] & ~mask) | (wdata & mask);
    if (p == 0) begin
      q0.push_back(e);
      req0 = 1'b1; we0 = we; be0 = be; addr0 = addr; wdata0 = wdata;
    end else begin
      q1.push_back(e);
      req1 = 1'b1; we1 = we; be1 = be; addr1 = addr; wdata1 = wdata;
    end
  endtask

  task automatic release_port(input int p);
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic wait_gnt(input int p);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if ((p == 0) ? gnt0 : gnt1) return;
    end
    checkOutput("gnt_timeout", 32'(p), 32'hFFFF_FFFF);
  endtask

  task automatic run_port(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      int          gap;
      int          word;
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      gap  = int'($urandom_range(0, 2));
      repeat (gap) step();
      we   = 1'($urandom_range(0, 1));
      be   = 4'($urandom);
      word = p * 16 + int'($urandom_range(0, 15));
      addr = 32'(word * 4) | 32'($urandom_range(0, 3));
      applyStimulus(p, we, be, addr, $urandom);
      wait_gnt(p);
      step();
      release_port(p);
    end
  endtask

  task automatic mon_port(input int p, input logic g, input logic rv);
    exp_t e;
    int   qs;
    if (rv || pend[p]) begin
      checkOutput((p == 0) ? "rvalid0" : "rvalid1", 32'(rv), 32'(pend[p]));
      if (rv && pend[p])
        checkOutput((p == 0) ? "rdata0" : "rdata1", rdata, pend_data[p]);
    end
    pend[p] = 1'b0;
    if (g) begin
      qs = (p == 0) ? q0.size() : q1.size();
      checkOutput((p == 0) ? "gnt0_has_req" : "gnt1_has_req", 32'(qs != 0), 32'd1);
      if (qs != 0) begin
        e = (p == 0) ? q0.pop_front() : q1.pop_front();
        if (e.is_load) begin
          pend[p]      = 1'b1;
          pend_data[p] = e.data;
        end
      end
    end
  endtask

  // Monitor: pops expected responses whenever the DUT grants or returns data.
  initial begin
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (gnt0 || gnt1) checkOutput("gnt_exclusive", 32'(gnt0 && gnt1), 32'd0);
      if (mem_we) checkOutput("mem_we_commit", 32'(busy || gnt0 || gnt1), 32'd1);
      mon_port(0, gnt0, rvalid0);
      mon_port(1, gnt1, rvalid1);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] saved;
    int          cnt0, cnt1, ek;
    rst = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; be0 = 0; be1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    #1;
    preload(5, 32'hDEADBEEF);
    preload(3, 32'h11223344);
    preload(9, 32'h5A5A5A5A);

    // Reset state.
    @(negedge clk);
    checkOutput("reset_ctrl", {26'h0, gnt0, gnt1, rvalid0, rvalid1, busy, mem_we}, 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'h0);

    // Uncontended load: gnt in cycle 0, data in cycle 1.
    step();
    rst = 1'b1;
    applyStimulus(0, 1'b0, 4'h0, 32'h14, 32'h0);
    @(negedge clk);
    checkOutput("load_gnt0", 32'(gnt0), 32'd1);
    checkOutput("load_mem_addr", 32'(mem_addr), 32'd5);
    step(); release_port(0);
    @(negedge clk);
    checkOutput("load_rvalid0", 32'(rvalid0), 32'd1);
    checkOutput("load_rdata", rdata, 32'hDEADBEEF);

    // Partial store from port 1 becomes a two-cycle RMW.
    step();
    applyStimulus(1, 1'b1, 4'b0010, 32'h0C, 32'h0000AA00);
    @(negedge clk);
    checkOutput("rmw_c0_gnt1", 32'(gnt1), 32'd0);
    checkOutput("rmw_c0_busy", 32'(busy), 32'd0);
    step();
    @(negedge clk);
    checkOutput("rmw_c1_busy", 32'(busy), 32'd1);
    checkOutput("rmw_c1_we", 32'(mem_we), 32'd1);
    checkOutput("rmw_c1_wdata", mem_wdata, 32'h1122AA44);
    checkOutput("rmw_c1_gnt1", 32'(gnt1), 32'd1);
    step(); release_port(1);
    applyStimulus(1, 1'b0, 4'h0, 32'h0C, 32'h0);
    step(); release_port(1);
    @(negedge clk);
    checkOutput("rmw_readback", rdata, 32'h1122AA44);

    // Round-robin vs fixed priority with both ports streaming full stores.
    step(); rst = 1'b0;
    step(); rst = 1'b1;
    applyStimulus(0, 1'b1, 4'hF, 32'(40 * 4), 32'hA000_0000);
    applyStimulus(1, 1'b1, 4'hF, 32'(41 * 4), 32'hB000_0000);
    cnt0 = 1; cnt1 = 1;
    for (int k = 0; k < 5; k++) begin
      ek = k % 2;
      @(negedge clk);
      checkOutput("rr_gnt0", 32'(gnt0), 32'(ek == 0));
      checkOutput("rr_gnt1", 32'(gnt1), 32'(ek == 1));
      if (k < 4) checkOutput("fp_gnt", {30'h0, fp_gnt0, fp_gnt1}, 32'h2);
      step();
      if (ek == 0) begin
        if (cnt0 < 3) begin applyStimulus(0, 1'b1, 4'hF, 32'(40 * 4), 32'hA000_0000 + 32'(cnt0)); cnt0++; end
        else release_port(0);
      end else begin
        if (cnt1 < 2) begin applyStimulus(1, 1'b1, 4'hF, 32'(41 * 4), 32'hB000_0000 + 32'(cnt1)); cnt1++; end
        else release_port(1);
      end
    end

    // Port 1 must wait out port 0's RMW lock.
    applyStimulus(0, 1'b1, 4'b0001, 32'h1C, 32'h000000C3);
    @(negedge clk);
    checkOutput("lock_c0", {30'h0, gnt0, gnt1}, 32'h0);
    step();
    applyStimulus(1, 1'b1, 4'hF, 32'hA8, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("lock_c1", {29'h0, busy, gnt0, gnt1}, 32'h6);
    step(); release_port(0);
    @(negedge clk);
    checkOutput("lock_c2", {29'h0, busy, gnt0, gnt1}, 32'h1);
    step(); release_port(1);

    // Reset during RMW aborts the write.
    saved = ref_mem[9];
    applyStimulus(0, 1'b1, 4'b0100, 32'h24, 32'h00FF0000);
    @(negedge clk);
    checkOutput("abort_c0_gnt0", 32'(gnt0), 32'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_quiet", {29'h0, mem_we, gnt0, busy}, 32'h0);
    step(); rst = 1'b1; release_port(0);
    q0.delete();
    ref_mem[9] = saved;
    @(negedge clk);
    checkOutput("abort_mem_kept", mem[9], 32'h5A5A5A5A);
    checkOutput("abort_idle", 32'(busy), 32'd0);
    step();
    applyStimulus(0, 1'b0, 4'h0, 32'h24, 32'h0);
    @(negedge clk);
    checkOutput("abort_then_gnt0", 32'(gnt0), 32'd1);
    step(); release_port(0);

    // be=0 store changes nothing; byte-offset address bits are ignored.
    applyStimulus(0, 1'b1, 4'h0, 32'h14, 32'h12345678);
    @(negedge clk);
    checkOutput("be0_gnt0", 32'(gnt0), 32'd1);
    checkOutput("be0_mem_we", 32'(mem_we), 32'd0);
    step(); release_port(0);
    applyStimulus(0, 1'b0, 4'h0, 32'h17, 32'h0);
    @(negedge clk);
    checkOutput("misaligned_addr", 32'(mem_addr), 32'd5);
    step(); release_port(0);
    @(negedge clk);
    checkOutput("misaligned_rdata", rdata, 32'hDEADBEEF);

    // Randomized concurrent traffic, each port in its own address region.
    step();
    fork
      run_port(0, 150);
      run_port(1, 150);
    join
    repeat (3) step();
    checkOutput("q0_drained", 32'(q0.size()), 32'd0);
    checkOutput("q1_drained", 32'(q1.size()), 32'd0);
    for (int i = 0; i < 48; i++) checkOutput($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port word data memory between two requesters: port 0 is the CPU memory stage, port 1 is a secondary master (debug/DMA).
- The memory has a combinational read and a synchronous word write.
- Performs round-robin or fixed-priority arbitration.
- Converts byte-enabled partial stores into a two-cycle read-modify-write, so the memory only ever sees whole-word writes.

Parameters:
- AW, 12, word-address width driven to the memory; word index = addr[AW+1:2].
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0, req1  input  1 each  access request, held high until the matching gnt.
- we0, we1  input  1 each  1 = store, 0 = load.
- be0, be1  input  4 each  byte enables for stores; bit k covers data[8k+7:8k]; ignored for loads.
- addr0, addr1  input  32 each  byte address; bits [1:0] are ignored.
- wdata0, wdata1  input  32 each  store data.
- gnt0, gnt1  output  1 each  one-cycle pulse: the request has been committed to memory.
- rvalid0, rvalid1  output  1 each  one-cycle pulse, the cycle after a load's gnt.
- rdata  output  32  registered load data; valid while an rvalid is high.
- busy  output  1  high while in state RMW.
- mem_addr  output  AW  word address to memory.
- mem_we  output  1  memory write enable.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  combinational memory read data.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; last_grant = 1, so port 0 is favoured next.
  - gnt0/1 = 0, rvalid0/1 = 0, rdata = 0, busy = 0.
  - mem_we forced 0; mem_addr and mem_wdata = 0.
- Requester contract: req, we, be, addr and wdata stay stable from req rising until the gnt cycle inclusive. The arbiter does not check this.
- Arbitration happens only in IDLE, combinationally each cycle.
  - Only one request high: that port wins.
  - Both high, FIXED_PRIO = 0: the port other than last_grant wins. last_grant updates on the edge ending that port's gnt cycle.
  - Both high, FIXED_PRIO = 1: port 0 wins.
  - The losing port sees no gnt and keeps waiting.
- IDLE, winner is a load:
  - mem_addr = winner addr[AW+1:2]; gnt pulses this cycle.
  - At the edge, rdata <= mem_rdata; the winner's rvalid is high for the next cycle.
  - Total latency: req to rvalid = 1 cycle when uncontended.
- IDLE, winner is a full-word store (be = 4'b1111): mem_we = 1, mem_wdata = wdata, gnt this cycle, 0-cycle latency.
- IDLE, winner is a store with be = 0: gnt this cycle, mem_we = 0, memory unchanged.
- IDLE, winner is a partial store (be neither 0 nor 4'b1111):
  - No gnt this cycle; mem_addr is driven.
  - At the edge: merge <= (mem_rdata & ~mask) | (wdata & mask), where mask expands be to bytes. Latch port id and word address; state -> RMW.
- RMW:
  - busy = 1; mem_addr = latched address; mem_we = 1; mem_wdata = merge.
  - The latched port's gnt pulses; the next state is IDLE.
  - No arbitration in RMW; the other port waits. The lock is held for exactly 1 extra cycle.
- Back-to-back: after any gnt a new arbitration happens in the very next IDLE cycle. A port may re-request immediately.
- A load's rvalid cycle may coincide with a new grant to either port. rdata and rvalid are independent of the new access.
- Reset asserted in RMW: the write is aborted (no mem_we), no gnt, no rvalid, state IDLE.
- Reset asserted the cycle after a load gnt: rvalid is suppressed.
- gnt0 and gnt1 are never high in the same cycle.
- mem_we is high only in a full-word-store IDLE grant or in RMW.

Test Plan:
- Reset then load: rst low 2 cycles, preload word 5 = 32'hDEADBEEF, req0 load addr 32'h14 → gnt0 in cycle 0, rvalid0 = 1 and rdata = 32'hDEADBEEF in cycle 1.
- Partial store: word 3 = 32'h11223344; req1 store addr 32'h0C, be = 4'b0010, wdata = 32'h0000AA00 → cycle 0 no gnt; cycle 1 busy = 1, mem_we = 1, mem_wdata = 32'h1122AA44, gnt1; a later read returns 32'h1122AA44.
- Round-robin: FIXED_PRIO = 0, req0 and req1 both held for 4 full-word store grants → grant order 0, 1, 0, 1 after reset. With FIXED_PRIO = 1 → 0, 0, 0, 0 while req0 is held.
- Lock during RMW: port0 partial store, then req1 full-word store raised in the same cycle → port0's RMW finishes (gnt0 in cycle 1); gnt1 in cycle 2, never in cycle 1.
- Reset mid-RMW: rst low in the RMW cycle → mem_we stays 0, memory word unchanged, gnt0 = 0; the state is IDLE after release.
- be = 0 store and misaligned address: store be = 0 → gnt in 1 cycle, memory unchanged. Load addr 32'h17 → same data as addr 32'h14.
